// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns core load/store requests into word-indexed RAM cycles,
// with sub-word load extraction and read-modify-write for byte/halfword stores.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic        MemREn,
  output logic        MemWEn,
  output logic [31:0] MemAddr,
  output logic [31:0] MemDataWrite,
  input  logic [31:0] MemDataRead
);

  typedef enum logic [1:0] {StIdle, StRead, StRmwRd, StWrite} state_e;

  state_e            state_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       merge_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_data_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_d;

  always_comb begin
    req_err = (ReqSize == 2'b11) ||
              ((ReqSize == 2'b01) && ReqAddr[0]) ||
              ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00)) ||
              (ReqAddr[31:2] >= 30'(DEPTH_WORDS));
  end

  // Load lane extraction and sub-word merge, both keyed off the captured request.
  always_comb begin
    byte_sel = MemDataRead[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = MemDataRead[7:0];
      2'd1:    byte_sel = MemDataRead[15:8];
      2'd2:    byte_sel = MemDataRead[23:16];
      default: byte_sel = MemDataRead[31:24];
    endcase
    half_sel = addr_q[1] ? MemDataRead[31:16] : MemDataRead[15:0];

    load_data = MemDataRead;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_data = MemDataRead;
    endcase

    merge_d = MemDataRead;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_d[7:0]   = data_q[7:0];
        2'd1:    merge_d[15:8]  = data_q[7:0];
        2'd2:    merge_d[23:16] = data_q[7:0];
        default: merge_d[31:24] = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_d[31:16] = data_q[15:0];
    end else begin
      merge_d[15:0] = data_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= '0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      case (state_q)
        StIdle: begin
          if (ReqValid) begin
            size_q   <= ReqSize;
            signed_q <= ReqSigned;
            addr_q   <= ReqAddr[ADDR_W+1:0];
            data_q   <= ReqData;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!ReqWrite) begin
              state_q <= StRead;
            end else if (ReqSize == 2'b10) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StRead: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= load_data;
          state_q      <= StIdle;
        end
        StRmwRd: begin
          merge_q <= merge_d;
          state_q <= StWrite;
        end
        StWrite: begin
          resp_valid_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ReqReady  = (state_q == StIdle);
  assign RespValid = resp_valid_q;
  assign RespErr   = resp_err_q;
  assign RespData  = resp_data_q;

  // Enables are gated by rst directly so an in-flight write is dropped in the reset cycle.
  assign MemREn       = !rst && ((state_q == StRead) || (state_q == StRmwRd));
  assign MemWEn       = !rst && (state_q == StWrite);
  assign MemAddr      = (state_q == StIdle) ? 32'h0 : 32'(addr_q[ADDR_W+1:2]);
  assign MemDataWrite = (state_q != StWrite) ? 32'h0 :
                        (size_q == 2'b10)    ? data_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: RAM model, scoreboard of expected responses
// (data, error flag and arrival cycle) checked by a negedge monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqData;
  logic        RespValid, RespErr;
  logic [31:0] RespData;
  logic        MemREn, MemWEn;
  logic [31:0] MemAddr, MemDataWrite, MemDataRead;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqData      (ReqData),
    .RespValid    (RespValid),
    .RespData     (RespData),
    .RespErr      (RespErr),
    .MemREn       (MemREn),
    .MemWEn       (MemWEn),
    .MemAddr      (MemAddr),
    .MemDataWrite (MemDataWrite),
    .MemDataRead  (MemDataRead)
  );

  always #5 clk = ~clk;

  // RAM model with a bench-side preload port.
  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_dat = 32'h0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (MemWEn && MemAddr < 32'd256) mem[MemAddr[7:0]] <= MemDataWrite;
  end
  assign MemDataRead = (MemAddr < 32'd256) ? mem[MemAddr[7:0]] : 32'h0;

  int cyc = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (MemWEn) wen_cnt <= wen_cnt + 1;
    if (MemREn) ren_cnt <= ren_cnt + 1;
  end

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    check("ren_wen_exclusive", 32'(MemREn & MemWEn), 32'h0);
    if (RespValid) begin
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_resp: observed RespValid=1 at cycle %0d expected none", cyc);
      end
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        check("resp_err", 32'(RespErr), 32'(mon_e.err));
        check("resp_data", RespData, mon_e.data);
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_dat = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Present a request at a negedge; lat = 0 means no response is expected.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] dt,
                       input int lat, input logic eerr, input logic [31:0] edata);
    exp_t e;
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = ad; ReqData = dt;
    check("req_ready_at_issue", 32'(ReqReady), 32'h1);
    if (lat > 0) begin
      e.cyc = cyc + lat; e.err = eerr; e.data = edata;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    ReqValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    tests++;
    assert (sbq.size() == 0) else begin
      fails++;
      $error("FAIL resp_timeout: observed %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w0, r0;

  initial begin
    rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
    ReqSigned = 1'b0; ReqAddr = 32'h0; ReqData = 32'h0;
    poke(8'd4, 32'h0);
    poke(8'd8, 32'h11223344);
    poke(8'd9, 32'hCAFEF00D);
    @(negedge clk);
    check("rst_resp_valid", 32'(RespValid), 32'h0);
    check("rst_resp_data", RespData, 32'h0);
    check("rst_mem_ren", 32'(MemREn), 32'h0);
    check("rst_mem_wen", 32'(MemWEn), 32'h0);
    check("rst_mem_addr", MemAddr, 32'h0);
    check("rst_req_ready", 32'(ReqReady), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store then word load.
    w0 = wen_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    check("wst_wen", 32'(MemWEn), 32'h1);
    check("wst_addr", MemAddr, 32'h4);
    check("wst_wdata", MemDataWrite, 32'hDEADBEEF);
    wait_done();
    check("wst_wen_count", 32'(wen_cnt - w0), 32'h1);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    check("wld_ren", 32'(MemREn), 32'h1);
    check("wld_addr", MemAddr, 32'h4);
    wait_done();

    // Byte store via RMW, then sub-word loads.
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 3, 1'b0, 32'h0);
    check("bst_rmw_ren", 32'(MemREn), 32'h1);
    wait_done();
    check("bst_mem", mem[4], 32'hDEADAAEF);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFAA); wait_done();
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'h000000AA); wait_done();
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD); wait_done();
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'h0000DEAD); wait_done();
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE); wait_done();
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFAAEF); wait_done();
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFEF); wait_done();
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 3, 1'b0, 32'h0); wait_done();
    check("hst_mem", mem[4], 32'h1234AAEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h1234AAEF); wait_done();

    // Error requests: no memory cycles at all.
    w0 = wen_cnt; r0 = ren_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'h0); wait_done();
    issue(1'b1, 2'b01, 1'b0, 32'h01, 32'hBEEF, 1, 1'b1, 32'h0); wait_done();
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b1, 32'h0); wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1, 1'b1, 32'h0); wait_done();
    issue(1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'h55, 1, 1'b1, 32'h0); wait_done();
    check("err_wen_count", 32'(wen_cnt - w0), 32'h0);
    check("err_ren_count", 32'(ren_cnt - r0), 32'h0);

    // Reset during RMW_RD of a byte store.
    w0 = wen_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h55, 0, 1'b0, 32'h0);
    rst = 1'b1; #1;
    check("rst_rmw_ren_forced", 32'(MemREn), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rmw_ready", 32'(ReqReady), 32'h1);
    repeat (4) @(negedge clk);
    check("rst_rmw_mem", mem[8], 32'h11223344);
    check("rst_rmw_wen_count", 32'(wen_cnt - w0), 32'h0);

    // Reset during WRITE of a byte store.
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h55, 0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rst_wr_wen_forced", 32'(MemWEn), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", 32'(ReqReady), 32'h1);
    repeat (4) @(negedge clk);
    check("rst_wr_mem", mem[8], 32'h11223344);
    check("rst_wr_wen_count", 32'(wen_cnt - w0), 32'h0);

    // Stall: requests held during a store are ignored; a load in the response cycle is taken.
    issue(1'b1, 2'b00, 1'b0, 32'h24, 32'h77, 3, 1'b0, 32'h0);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqAddr = 32'h30;
    @(negedge clk);
    check("stall_ready_rmw", 32'(ReqReady), 32'h0);
    @(posedge clk); #1;
    ReqAddr = 32'h34;
    @(negedge clk);
    check("stall_ready_write", 32'(ReqReady), 32'h0);
    @(posedge clk); #1;
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 2, 1'b0, 32'hCAFEF077);
    wait_done();
    check("stall_mem", mem[9], 32'hCAFEF077);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
